// File: rtl/icache_pkg.sv
// Shared types and width helpers for the parametrised direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_WORD_W     = 16;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned DEF_LINES      = 64;

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned line_words,
                                          input int unsigned lines);
        return addr_w - $clog2(line_words) - $clog2(lines);
    endfunction

    function automatic int unsigned line_w(input int unsigned word_w,
                                           input int unsigned line_words);
        return word_w * line_words;
    endfunction

endpackage

// File: rtl/icache_fill_seq.sv
// Line fill sequencer: walks one aligned line over the req/ack memory port,
// assembles it in a buffer, aborts on flush, and pulses done after the last word.
module icache_fill_seq
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [ADDR_W-off_w(LINE_WORDS)-1:0]     start_line,
    input  logic                                    flush,
    input  logic                                    mem_ack,
    input  logic [WORD_W-1:0]                       mem_data,
    output logic                                    mem_req,
    output logic [ADDR_W-1:0]                       mem_addr,
    output logic [ADDR_W-off_w(LINE_WORDS)-1:0]     fill_line,
    output logic                                    last_c,
    output logic                                    done,
    output logic [line_w(WORD_W, LINE_WORDS)-1:0]   line
);

    localparam int unsigned OFF_W = off_w(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

    logic [OFF_W-1:0]  k;
    logic [WORD_W-1:0] words [LINE_WORDS];
    logic              take;

    // A word is accepted only if the fill is not being aborted in the same cycle
    assign take   = mem_req && mem_ack && !flush;
    assign last_c = take && (k == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            fill_line <= '0;
            k         <= '0;
            done      <= 1'b0;
        end else begin
            done <= last_c;
            if (mem_req) begin
                if (flush) begin
                    mem_req <= 1'b0;
                end else if (mem_ack) begin
                    if (k == LAST) begin
                        mem_req <= 1'b0;
                    end else begin
                        k        <= k + OFF_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
            end else if (start) begin
                mem_req   <= 1'b1;
                mem_addr  <= {start_line, OFF_W'(0)};
                fill_line <= start_line;
                k         <= '0;
            end
        end
    end

    // Line buffer carries no reset; only committed lines ever become visible
    always_ff @(posedge clk) begin
        if (take) begin
            words[k] <= mem_data;
        end
    end

    always_comb begin
        line = '0;
        for (int i = 0; i < int'(LINE_WORDS); i++) begin
            line[i*WORD_W +: WORD_W] = words[i];
        end
    end

endmodule

// File: rtl/param_icache.sv
// Parametrised direct-mapped instruction cache returning a whole line per hit,
// with zero-latency hit path, line-aligned fills and invalidate-all flush.
module param_icache
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned LINES      = DEF_LINES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    input  logic [ADDR_W-1:0]                      req_addr,
    output logic                                   rsp_valid,
    output logic [line_w(WORD_W, LINE_WORDS)-1:0]  rsp_data,
    output logic [ADDR_W-1:0]                      rsp_base,
    output logic                                   rsp_wait,
    input  logic                                   flush,
    output logic                                   mem_req,
    output logic [ADDR_W-1:0]                      mem_addr,
    input  logic                                   mem_ack,
    input  logic [WORD_W-1:0]                      mem_data
);

    localparam int unsigned OFF_W  = off_w(LINE_WORDS);
    localparam int unsigned IDX_W  = idx_w(LINES);
    localparam int unsigned TAG_W  = tag_w(ADDR_W, LINE_WORDS, LINES);
    localparam int unsigned LINE_W = line_w(WORD_W, LINE_WORDS);
    localparam int unsigned LNUM_W = ADDR_W - OFF_W;

    state_t state_q, state_d;

    logic [LINE_W-1:0] data_arr [LINES];
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [LINES-1:0]  valid;

    logic [LNUM_W-1:0] req_line;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit_raw;
    logic              addr_off_unused;

    logic              start;
    logic              last_c;
    logic              done;
    logic [LNUM_W-1:0] fill_line;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [LINE_W-1:0] fill_data;

    // Whole lines are returned, so the word offset only matters to the fetch unit
    assign req_line        = req_addr[ADDR_W-1:OFF_W];
    assign addr_off_unused = ^req_addr[OFF_W-1:0];
    assign req_idx         = req_line[IDX_W-1:0];
    assign req_tag         = req_line[IDX_W +: TAG_W];
    assign fill_idx        = fill_line[IDX_W-1:0];
    assign fill_tag        = fill_line[IDX_W +: TAG_W];

    assign hit_raw   = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign rsp_valid = req_valid && (state_q == IDLE) && hit_raw;
    assign rsp_wait  = req_valid && !rsp_valid;
    assign rsp_data  = data_arr[req_idx];
    assign rsp_base  = {req_line, OFF_W'(0)};

    icache_fill_seq #(
        .ADDR_W     (ADDR_W),
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_fill_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_line (req_line),
        .flush      (flush),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .fill_line  (fill_line),
        .last_c     (last_c),
        .done       (done),
        .line       (fill_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !hit_raw && !flush) begin
                    start   = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last_c) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flush beats the commit's valid set; data/tag writes are harmless while invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (done) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (done) begin
            data_arr[fill_idx] <= fill_data;
            tag_arr[fill_idx]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_param_icache.sv
// Self-checking bench for param_icache: directed scenarios plus randomized fetches
// checked against a tag/valid table model and an address-derived memory image.
module tb_param_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic [31:0] rsp_base;
    logic        rsp_wait;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int mem_lat  = 1;
    logic [31:0] acked [$];

    bit          mv [64];
    logic [23:0] mt [64];

    param_icache #(.ADDR_W(32), .WORD_W(16), .LINE_WORDS(4), .LINES(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_base(rsp_base),
        .rsp_wait(rsp_wait), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return 16'hA000 + a[15:0];
    endfunction

    function automatic logic [63:0] exp_line(input logic [31:0] a);
        logic [31:0] b;
        logic [63:0] r;
        b = {a[31:2], 2'b00};
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = mem_word(b + 32'(i));
        return r;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mv[a[7:2]] && (mt[a[7:2]] == a[31:8]);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        mv[a[7:2]] = 1'b1;
        mt[a[7:2]] = a[31:8];
    endfunction

    function automatic void model_clear();
        foreach (mv[i]) mv[i] = 1'b0;
    endfunction

    // Memory responder: acks each word after mem_lat cycles; checks address stability while waiting
    always @(negedge clk) begin : responder
        static int          wcnt = 0;
        static logic [31:0] held = '0;
        if (!rst || !mem_req) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else begin
            if (wcnt > 0) begin
                n_checks++;
                if (mem_addr !== held)
                    $display("FAIL addr_stable: mem_addr=%h required %h", mem_addr, held);
                else
                    n_pass++;
            end else begin
                held = mem_addr;
            end
            if (wcnt >= mem_lat - 1) begin
                mem_ack  = 1'b1;
                mem_data = mem_word(mem_addr);
                acked.push_back(mem_addr);
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Present an address and wait (bounded) for the hit; reports what was observed
    task automatic fetch(input logic [31:0] a, output int cyc, output logic [63:0] line,
                         output logic [31:0] base, output int bad_wait, output bit saw_req);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        cyc = 0;
        bad_wait = 0;
        saw_req = (mem_req === 1'b1);
        while (rsp_valid !== 1'b1 && cyc < 200) begin
            if (rsp_wait !== 1'b1) bad_wait++;
            @(negedge clk);
            #1;
            cyc++;
            if (mem_req === 1'b1) saw_req = 1'b1;
        end
        if (rsp_wait !== 1'b0) bad_wait++;
        line = rsp_data;
        base = rsp_base;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h100;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_wait !== 1'b1) $display("FAIL reset_rsp_wait: got %b want 1", rsp_wait); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_cold_miss();
        int cyc, bw; logic [63:0] line; logic [31:0] base; bit sr;
        acked.delete();
        fetch(32'h100, cyc, line, base, bw, sr);
        model_fill(32'h100);
        n_checks++; if (cyc != 6) $display("FAIL cold_latency: got %0d want 6", cyc); else n_pass++;
        n_checks++; if (line !== 64'hA103_A102_A101_A100) $display("FAIL cold_data: got %h want A103A102A101A100", line); else n_pass++;
        n_checks++; if (base !== 32'h100) $display("FAIL cold_base: got %h want 100", base); else n_pass++;
        n_checks++; if (bw != 0) $display("FAIL cold_wait: %0d bad rsp_wait samples want 0", bw); else n_pass++;
        n_checks++; if (acked.size() != 4) $display("FAIL cold_nwords: got %0d want 4", acked.size()); else n_pass++;
        for (int i = 0; i < 4 && i < acked.size(); i++) begin
            n_checks++;
            if (acked[i] !== 32'h100 + 32'(i)) $display("FAIL cold_mem_addr%0d: got %h want %h", i, acked[i], 32'h100 + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_unaligned_hit();
        int cyc, bw; logic [63:0] line; logic [31:0] base; bit sr;
        logic [31:0] addrs [2] = '{32'h102, 32'h103};
        foreach (addrs[j]) begin
            fetch(addrs[j], cyc, line, base, bw, sr);
            n_checks++; if (cyc != 0) $display("FAIL hit_latency_%h: got %0d want 0", addrs[j], cyc); else n_pass++;
            n_checks++; if (sr) $display("FAIL hit_no_mem_req_%h: mem_req seen want none", addrs[j]); else n_pass++;
            n_checks++; if (line !== 64'hA103_A102_A101_A100) $display("FAIL hit_data_%h: got %h want A103A102A101A100", addrs[j], line); else n_pass++;
            n_checks++; if (base !== 32'h100) $display("FAIL hit_base_%h: got %h want 100", addrs[j], base); else n_pass++;
        end
    endtask

    task automatic test_conflict();
        int cyc, bw; logic [63:0] line; logic [31:0] base; bit sr;
        acked.delete();
        fetch(32'h200, cyc, line, base, bw, sr);
        model_fill(32'h200);
        n_checks++; if (cyc != 6) $display("FAIL evict_latency: got %0d want 6", cyc); else n_pass++;
        n_checks++; if (line !== exp_line(32'h200)) $display("FAIL evict_data: got %h want %h", line, exp_line(32'h200)); else n_pass++;
        n_checks++; if (acked.size() == 0 || acked[0] !== 32'h200) $display("FAIL evict_first_addr: got size %0d want first 200", acked.size()); else n_pass++;
        fetch(32'h100, cyc, line, base, bw, sr);
        model_fill(32'h100);
        n_checks++; if (cyc != 6) $display("FAIL refill_latency: got %0d want 6", cyc); else n_pass++;
        n_checks++; if (line !== exp_line(32'h100)) $display("FAIL refill_data: got %h want %h", line, exp_line(32'h100)); else n_pass++;
    endtask

    task automatic test_wait_state();
        int cyc, bw; logic [63:0] line; logic [31:0] base; bit sr;
        mem_lat = 3;
        fetch(32'h342, cyc, line, base, bw, sr);
        model_fill(32'h342);
        mem_lat = 1;
        n_checks++; if (cyc != 14) $display("FAIL wait_latency: got %0d want 14", cyc); else n_pass++;
        n_checks++; if (line !== exp_line(32'h340)) $display("FAIL wait_data: got %h want %h", line, exp_line(32'h340)); else n_pass++;
        n_checks++; if (base !== 32'h340) $display("FAIL wait_base: got %h want 340", base); else n_pass++;
        n_checks++; if (bw != 0) $display("FAIL wait_rsp_wait: %0d bad samples want 0", bw); else n_pass++;
    endtask

    task automatic test_top_of_memory();
        int cyc, bw; logic [63:0] line; logic [31:0] base; bit sr;
        fetch(32'hFFFF_FFFF, cyc, line, base, bw, sr);
        model_fill(32'hFFFF_FFFF);
        n_checks++; if (cyc != 6) $display("FAIL top_latency: got %0d want 6", cyc); else n_pass++;
        n_checks++; if (base !== 32'hFFFF_FFFC) $display("FAIL top_base: got %h want FFFFFFFC", base); else n_pass++;
        n_checks++; if (line !== exp_line(32'hFFFF_FFFC)) $display("FAIL top_data: got %h want %h", line, exp_line(32'hFFFF_FFFC)); else n_pass++;
    endtask

    task automatic test_flush();
        int cyc, bw, guard; logic [63:0] line; logic [31:0] base; bit sr;
        // Flush while word 2 is pending, with its ack in the same cycle
        acked.delete();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h480;
        guard = 0;
        while (!(mem_req === 1'b1 && mem_addr === 32'h482) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (guard >= 50) $display("FAIL flush_reach_word2: timeout want mem_addr 482"); else n_pass++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL flush_mem_req_drop: got %b want 0", mem_req); else n_pass++;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL flush_no_restart: got %b want 0", mem_req); else n_pass++;
        model_clear();
        acked.delete();
        fetch(32'h483, cyc, line, base, bw, sr);
        model_fill(32'h483);
        n_checks++; if (cyc != 6) $display("FAIL flush_refetch_latency: got %0d want 6", cyc); else n_pass++;
        n_checks++; if (acked.size() == 0 || acked[0] !== 32'h480) $display("FAIL flush_refetch_offset0: got size %0d want first 480", acked.size()); else n_pass++;
        n_checks++; if (line !== exp_line(32'h480)) $display("FAIL flush_refetch_data: got %h want %h", line, exp_line(32'h480)); else n_pass++;
        fetch(32'h100, cyc, line, base, bw, sr);
        model_fill(32'h100);
        n_checks++; if (cyc != 6) $display("FAIL flush_cleared_other: got %0d want 6", cyc); else n_pass++;

        // Flush and miss in the same idle cycle: flush only, miss taken next cycle
        @(negedge clk);
        req_addr = 32'h500;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL flush_miss_same_cycle: got %b want 0", mem_req); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) $display("FAIL flush_miss_retry: req %b addr %h want 1/500", mem_req, mem_addr); else n_pass++;
        model_clear();
        fetch(32'h500, cyc, line, base, bw, sr);
        model_fill(32'h500);
        n_checks++; if (line !== exp_line(32'h500)) $display("FAIL flush_miss_data: got %h want %h", line, exp_line(32'h500)); else n_pass++;

        // Flush landing on the commit cycle must win over the valid set
        @(negedge clk);
        req_addr = 32'h540;
        guard = 0;
        while (!(mem_req === 1'b1 && mem_addr === 32'h543) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        fetch(32'h540, cyc, line, base, bw, sr);
        model_fill(32'h540);
        n_checks++; if (cyc != 6) $display("FAIL flush_commit_latency: got %0d want 6", cyc); else n_pass++;
    endtask

    task automatic test_async_reset();
        int cyc, bw; logic [63:0] line; logic [31:0] base; bit sr;
        fetch(32'h100, cyc, line, base, bw, sr);
        model_fill(32'h100);
        @(negedge clk);
        req_addr = 32'h600;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL areset_pre_fill: mem_req %b want 1", mem_req); else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL areset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL areset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        req_addr = 32'h100;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL areset_invalidated: rsp_valid %b want 0", rsp_valid); else n_pass++;
        req_valid = 1'b0;
        model_clear();
        fetch(32'h100, cyc, line, base, bw, sr);
        model_fill(32'h100);
        n_checks++; if (cyc != 6) $display("FAIL areset_refill_latency: got %0d want 6", cyc); else n_pass++;
    endtask

    task automatic test_random();
        int cyc, bw, exp_cyc; logic [63:0] line; logic [31:0] base, a; bit sr, exp_hit;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(7) == 0) begin
                @(negedge clk);
                flush = 1'b1;
                req_valid = 1'b0;
                @(negedge clk);
                flush = 1'b0;
                model_clear();
            end
            mem_lat = int'($urandom_range(3, 1));
            a = (32'($urandom_range(2)) << 8) | (32'($urandom_range(3)) << 2) | 32'($urandom_range(3));
            exp_hit = model_hit(a);
            exp_cyc = exp_hit ? 0 : 2 + 4 * mem_lat;
            fetch(a, cyc, line, base, bw, sr);
            model_fill(a);
            n_checks++; if (cyc != exp_cyc) $display("FAIL rand_latency_%h: got %0d want %0d", a, cyc, exp_cyc); else n_pass++;
            n_checks++; if (line !== exp_line(a)) $display("FAIL rand_data_%h: got %h want %h", a, line, exp_line(a)); else n_pass++;
            n_checks++; if (base !== {a[31:2], 2'b00}) $display("FAIL rand_base_%h: got %h want %h", a, base, {a[31:2], 2'b00}); else n_pass++;
        end
        mem_lat = 1;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_unaligned_hit();
        test_conflict();
        test_wait_state();
        test_top_of_memory();
        test_flush();
        test_async_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
